// File: rtl/tl_tag_mgr_pkg.sv
// Shared constants and payload types for the non-posted tag manager.
package tl_tag_mgr_pkg;

  localparam int unsigned TL_TAG_W       = 8;
  localparam int unsigned TL_NUM_TAGS    = 32;
  localparam int unsigned TL_CPL_TIMEOUT = 4096;

  // Timeout report: which tag was retired because no completion arrived.
  typedef struct packed {
    logic                valid;
    logic [TL_TAG_W-1:0] tag;
  } tl_tag_evt_t;

endpackage

// File: rtl/tl_tag_mgr_if.sv
// Tag offer / completion bus between tl_tag_mgr and its requester and completion source.
interface tl_tag_mgr_if
  import tl_tag_mgr_pkg::*;
#(
  parameter int unsigned TAG_W    = TL_TAG_W,
  parameter int unsigned NUM_TAGS = TL_NUM_TAGS
);

  localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);

  logic [TAG_W-1:0] tag_o;
  logic             tag_valid_o;
  logic             tag_consume_i;
  logic             cpl_valid_i;
  logic [TAG_W-1:0] cpl_tag_i;
  logic             cpl_last_i;
  logic [CNT_W-1:0] outstanding_o;
  logic             timeout_o;
  logic [TAG_W-1:0] timeout_tag_o;
  logic             unexp_cpl_o;

  // Tag manager side.
  modport slave (
    output tag_o, tag_valid_o, outstanding_o, timeout_o, timeout_tag_o, unexp_cpl_o,
    input  tag_consume_i, cpl_valid_i, cpl_tag_i, cpl_last_i
  );

  // Requester / completion source side.
  modport master (
    input  tag_o, tag_valid_o, outstanding_o, timeout_o, timeout_tag_o, unexp_cpl_o,
    output tag_consume_i, cpl_valid_i, cpl_tag_i, cpl_last_i
  );

endinterface

// File: rtl/tl_lsb_enc.sv
// Combinational lowest-set-bit finder with a found flag.
module tl_lsb_enc #(
  parameter int unsigned N     = 32,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_found_c
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx_c   = '0;
    o_found_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx_c   = IDX_W'(i);
        o_found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_tag_mgr.sv
// Non-posted tag pool: offers free tags, tracks outstanding ones, retires them
// on final completion or timeout, and flags completions for tags not in flight.
module tl_tag_mgr
  import tl_tag_mgr_pkg::*;
#(
  parameter int unsigned TAG_W          = TL_TAG_W,
  parameter int unsigned NUM_TAGS       = TL_NUM_TAGS,
  parameter int unsigned TIMEOUT_CYCLES = TL_CPL_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  tl_tag_mgr_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);
  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(TIMEOUT_CYCLES);

  // Pool state
  logic [NUM_TAGS-1:0] r_busy;
  logic [AGE_W-1:0]    r_age [NUM_TAGS];

  // Registered outputs
  logic [TAG_W-1:0]    r_tag;
  logic                r_tag_valid;
  logic [CNT_W-1:0]    r_outstanding;
  tl_tag_evt_t         r_timeout_evt;
  logic                r_unexp;

  // Per-cycle event decode
  logic                w_consume;
  logic                w_load_offer;
  logic [NUM_TAGS-1:0] w_consume_vec;
  logic [NUM_TAGS-1:0] w_cpl_hit;
  logic [NUM_TAGS-1:0] w_cpl_free;
  logic [NUM_TAGS-1:0] w_cand;
  logic [NUM_TAGS-1:0] w_to_vec;
  logic [NUM_TAGS-1:0] w_free_vec;
  logic                w_cpl_busy;
  logic                w_cpl_final;
  logic                w_unexp;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_free_found;
  logic [IDX_W-1:0]    w_to_idx;
  logic                w_to_found;

  assign w_consume    = bus.tag_consume_i & r_tag_valid;
  assign w_load_offer = ~r_tag_valid | w_consume;

  // Decode consume target, completion hit and timeout candidates per tag.
  // A tag that receives any completion this cycle is not a timeout candidate,
  // so a final completion racing its own timeout retires it without a pulse.
  always_comb begin
    w_consume_vec = '0;
    w_cpl_hit     = '0;
    w_cand        = '0;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      w_consume_vec[i] = w_consume && (r_tag == TAG_W'(i));
      w_cpl_hit[i]     = bus.cpl_valid_i && r_busy[i] && (bus.cpl_tag_i == TAG_W'(i));
      w_cand[i]        = r_busy[i] && (r_age[i] == AGE_SAT) && !w_cpl_hit[i];
    end
  end

  assign w_cpl_busy  = |w_cpl_hit;
  assign w_cpl_final = w_cpl_busy & bus.cpl_last_i;
  assign w_cpl_free  = w_cpl_hit & {NUM_TAGS{bus.cpl_last_i}};
  assign w_unexp     = bus.cpl_valid_i & ~w_cpl_busy;

  // The offered tag is never busy, but exclude it when it is being taken now.
  assign w_free_vec  = ~r_busy & ~w_consume_vec;

  tl_lsb_enc #(
    .N     (NUM_TAGS),
    .IDX_W (IDX_W)
  ) u_free_enc (
    .i_vec     (w_free_vec),
    .o_idx_c   (w_free_idx),
    .o_found_c (w_free_found)
  );

  tl_lsb_enc #(
    .N     (NUM_TAGS),
    .IDX_W (IDX_W)
  ) u_to_enc (
    .i_vec     (w_cand),
    .o_idx_c   (w_to_idx),
    .o_found_c (w_to_found)
  );

  // One-hot of the single tag retired by timeout this cycle.
  always_comb begin
    w_to_vec = '0;
    for (int i = 0; i < int'(NUM_TAGS); i++) begin
      w_to_vec[i] = w_to_found && (w_to_idx == IDX_W'(i));
    end
  end

  // Busy bitmap and per-tag age counters; free tags hold age zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
        r_age[i] <= '0;
      end
    end else begin
      r_busy <= (r_busy & ~w_cpl_free & ~w_to_vec) | w_consume_vec;
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
        if (w_consume_vec[i] || w_cpl_hit[i] || !r_busy[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AGE_SAT) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end

  // Offer register: reload only when empty or when the current offer is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
    end else if (w_load_offer) begin
      r_tag       <= w_free_found ? TAG_W'(w_free_idx) : '0;
      r_tag_valid <= w_free_found;
    end
  end

  // Outstanding count tracks +consume - completion free - timeout free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_consume)
                       - CNT_W'(w_cpl_final) - CNT_W'(w_to_found);
    end
  end

  // Event pulses: timeout report and unexpected completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_evt <= '0;
      r_unexp       <= 1'b0;
    end else begin
      r_timeout_evt.valid <= w_to_found;
      r_timeout_evt.tag   <= w_to_found ? TL_TAG_W'(w_to_idx) : '0;
      r_unexp             <= w_unexp;
    end
  end

  assign bus.tag_o         = r_tag;
  assign bus.tag_valid_o   = r_tag_valid;
  assign bus.outstanding_o = r_outstanding;
  assign bus.timeout_o     = r_timeout_evt.valid;
  assign bus.timeout_tag_o = TAG_W'(r_timeout_evt.tag);
  assign bus.unexp_cpl_o   = r_unexp;

endmodule

// File: tb/tb_tl_tag_mgr.sv
// Bench for tl_tag_mgr: directed scenarios plus randomized traffic against a
// behavioural model of the tag pool (TIMEOUT_CYCLES reduced to 16).
module tb_tl_tag_mgr;

  localparam int unsigned TAG_W = 8;
  localparam int          NT    = 32;
  localparam int          TO    = 16;
  localparam int unsigned CNT_W = $clog2(NT + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tl_tag_mgr_if #(.TAG_W(TAG_W), .NUM_TAGS(NT)) tl ();

  tl_tag_mgr #(
    .TAG_W          (TAG_W),
    .NUM_TAGS       (NT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tl.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which tags are in flight, how long since each was last
  // heard from, and the values the outputs should show after each edge.
  bit m_busy [NT];
  int m_age  [NT];
  int m_tag;
  bit m_valid;
  int m_out;
  bit m_to;
  int m_to_tag;
  bit m_unexp;

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_busy[i] = 1'b0;
      m_age[i]  = 0;
    end
    m_tag = 0; m_valid = 1'b0; m_out = 0;
    m_to = 1'b0; m_to_tag = 0; m_unexp = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit cv, input int ct, input bit cl);
    bit cons;
    bit hit;
    int to_idx;
    int nxt;
    bit n_valid;
    int n_tag;
    cons = c && m_valid;
    hit  = 1'b0;
    if (cv && ct >= 0 && ct < NT) hit = m_busy[ct];
    // Oldest-rule: lowest tag silent for TO cycles, unless it just got a completion.
    to_idx = -1;
    for (int i = 0; i < NT; i++)
      if (to_idx < 0 && m_busy[i] && m_age[i] >= TO && !(hit && ct == i)) to_idx = i;
    n_valid = m_valid;
    n_tag   = m_tag;
    if (!m_valid || cons) begin
      nxt = -1;
      for (int i = 0; i < NT; i++)
        if (nxt < 0 && !m_busy[i] && !(cons && i == m_tag)) nxt = i;
      n_valid = (nxt >= 0);
      n_tag   = (nxt >= 0) ? nxt : 0;
    end
    for (int i = 0; i < NT; i++)
      if (m_busy[i]) m_age[i] = (hit && ct == i) ? 0 : ((m_age[i] + 1 > TO) ? TO : m_age[i] + 1);
    if (hit && cl) begin m_busy[ct] = 1'b0; m_out = m_out - 1; end
    if (to_idx >= 0) begin m_busy[to_idx] = 1'b0; m_out = m_out - 1; end
    if (cons) begin m_busy[m_tag] = 1'b1; m_age[m_tag] = 0; m_out = m_out + 1; end
    m_unexp  = cv && !hit;
    m_to     = (to_idx >= 0);
    m_to_tag = m_to ? to_idx : 0;
    m_valid  = n_valid;
    m_tag    = n_tag;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // return at the next falling edge with outputs settled.
  task automatic step(input bit c, input bit cv, input int ct, input bit cl);
    tl.tag_consume_i = c;
    tl.cpl_valid_i   = cv;
    tl.cpl_tag_i     = TAG_W'(ct);
    tl.cpl_last_i    = cl;
    model_step(c, cv, ct, cl);
    @(posedge clk);
    @(negedge clk);
    tl.tag_consume_i = 1'b0;
    tl.cpl_valid_i   = 1'b0;
    tl.cpl_tag_i     = '0;
    tl.cpl_last_i    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (tl.tag_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%0b exp=0", tl.tag_valid_o); end
    n_checks++; if (tl.tag_o !== '0) begin n_errors++; $display("FAIL rst_tag got=%0d exp=0", tl.tag_o); end
    n_checks++; if (tl.outstanding_o !== '0) begin n_errors++; $display("FAIL rst_out got=%0d exp=0", tl.outstanding_o); end
    n_checks++; if (tl.timeout_o !== 1'b0) begin n_errors++; $display("FAIL rst_to got=%0b exp=0", tl.timeout_o); end
    n_checks++; if (tl.timeout_tag_o !== '0) begin n_errors++; $display("FAIL rst_to_tag got=%0d exp=0", tl.timeout_tag_o); end
    n_checks++; if (tl.unexp_cpl_o !== 1'b0) begin n_errors++; $display("FAIL rst_unexp got=%0b exp=0", tl.unexp_cpl_o); end
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 0, 1'b0);
    n_checks++; if (tl.tag_valid_o !== 1'b1) begin n_errors++; $display("FAIL first_offer_valid got=%0b exp=1", tl.tag_valid_o); end
    n_checks++; if (tl.tag_o !== 8'd0) begin n_errors++; $display("FAIL first_offer_tag got=%0d exp=0", tl.tag_o); end
    step(1'b1, 1'b0, 0, 1'b0);
    n_checks++; if (tl.tag_o !== 8'd1) begin n_errors++; $display("FAIL second_offer_tag got=%0d exp=1", tl.tag_o); end
    n_checks++; if (tl.outstanding_o !== CNT_W'(1)) begin n_errors++; $display("FAIL first_consume_out got=%0d exp=1", tl.outstanding_o); end
  endtask

  // Fill the pool; completions (last=0) keep early tags alive while filling.
  task automatic test_back_to_back();
    for (int k = 1; k < NT; k++) begin
      step(1'b1, k >= 16, k - 16, 1'b0);
      n_checks++; if (tl.outstanding_o !== CNT_W'(k + 1)) begin n_errors++; $display("FAIL fill_out k=%0d got=%0d exp=%0d", k, tl.outstanding_o, k + 1); end
    end
    n_checks++; if (tl.tag_valid_o !== 1'b0) begin n_errors++; $display("FAIL full_valid got=%0b exp=0", tl.tag_valid_o); end
    n_checks++; if (tl.outstanding_o !== CNT_W'(NT)) begin n_errors++; $display("FAIL full_out got=%0d exp=%0d", tl.outstanding_o, NT); end
    n_checks++; if (tl.timeout_o !== 1'b0) begin n_errors++; $display("FAIL full_no_to got=%0b exp=0", tl.timeout_o); end
    step(1'b0, 1'b1, 5, 1'b1);
    n_checks++; if (tl.tag_valid_o !== 1'b0) begin n_errors++; $display("FAIL free5_valid_early got=%0b exp=0", tl.tag_valid_o); end
    n_checks++; if (tl.outstanding_o !== CNT_W'(NT - 1)) begin n_errors++; $display("FAIL free5_out got=%0d exp=%0d", tl.outstanding_o, NT - 1); end
    step(1'b0, 1'b0, 0, 1'b0);
    n_checks++; if (tl.tag_valid_o !== 1'b1) begin n_errors++; $display("FAIL reoffer_valid got=%0b exp=1", tl.tag_valid_o); end
    n_checks++; if (tl.tag_o !== 8'd5) begin n_errors++; $display("FAIL reoffer_tag got=%0d exp=5", tl.tag_o); end
    n_checks++; if (tl.timeout_o !== 1'b1 || tl.timeout_tag_o !== 8'd0) begin n_errors++; $display("FAIL fill_tag0_to got=%0b/%0d exp=1/0", tl.timeout_o, tl.timeout_tag_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    for (int n = 1; n <= TO + 1; n++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      n_checks++; if (tl.timeout_o !== (n == TO + 1)) begin n_errors++; $display("FAIL to_pulse n=%0d got=%0b exp=%0b", n, tl.timeout_o, n == TO + 1); end
    end
    n_checks++; if (tl.timeout_tag_o !== 8'd0) begin n_errors++; $display("FAIL to_tag got=%0d exp=0", tl.timeout_tag_o); end
    n_checks++; if (tl.outstanding_o !== '0) begin n_errors++; $display("FAIL to_out got=%0d exp=0", tl.outstanding_o); end
    step(1'b0, 1'b0, 0, 1'b0);
    n_checks++; if (tl.timeout_o !== 1'b0) begin n_errors++; $display("FAIL to_one_cycle got=%0b exp=0", tl.timeout_o); end
    step(1'b1, 1'b0, 0, 1'b0);
    n_checks++; if (tl.tag_o !== 8'd0) begin n_errors++; $display("FAIL to_tag0_reused got=%0d exp=0", tl.tag_o); end
  endtask

  // Tag 3 kept alive by a partial completion, then finished in its timeout cycle.
  task automatic test_cpl_refresh();
    do_reset();
    step(1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 0, 1'b0);
    for (int t = 1; t <= 28; t++) begin
      if (t <= 3)       step(1'b0, 1'b1, t - 1, 1'b1);
      else if (t == 10) step(1'b0, 1'b1, 3, 1'b0);
      else if (t == 27) step(1'b0, 1'b1, 3, 1'b1);
      else              step(1'b0, 1'b0, 0, 1'b0);
      n_checks++; if (tl.timeout_o !== 1'b0) begin n_errors++; $display("FAIL refresh_no_to t=%0d got=%0b exp=0", t, tl.timeout_o); end
      if (t == 27) begin
        n_checks++; if (tl.outstanding_o !== '0) begin n_errors++; $display("FAIL refresh_out got=%0d exp=0", tl.outstanding_o); end
      end
    end
  endtask

  task automatic test_unexpected();
    do_reset();
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 7, 1'b1);
    n_checks++; if (tl.unexp_cpl_o !== 1'b1) begin n_errors++; $display("FAIL unexp_free7 got=%0b exp=1", tl.unexp_cpl_o); end
    n_checks++; if (tl.outstanding_o !== CNT_W'(1)) begin n_errors++; $display("FAIL unexp_free7_out got=%0d exp=1", tl.outstanding_o); end
    n_checks++; if (tl.tag_valid_o !== 1'b1 || tl.tag_o !== 8'd1) begin n_errors++; $display("FAIL unexp_offer got=%0b/%0d exp=1/1", tl.tag_valid_o, tl.tag_o); end
    step(1'b0, 1'b0, 0, 1'b0);
    n_checks++; if (tl.unexp_cpl_o !== 1'b0) begin n_errors++; $display("FAIL unexp_pulse_len got=%0b exp=0", tl.unexp_cpl_o); end
    step(1'b0, 1'b1, 40, 1'b0);
    n_checks++; if (tl.unexp_cpl_o !== 1'b1) begin n_errors++; $display("FAIL unexp_range40 got=%0b exp=1", tl.unexp_cpl_o); end
    step(1'b0, 1'b1, 0, 1'b0);
    n_checks++; if (tl.unexp_cpl_o !== 1'b0) begin n_errors++; $display("FAIL expected_cpl0 got=%0b exp=0", tl.unexp_cpl_o); end
    n_checks++; if (tl.outstanding_o !== CNT_W'(1)) begin n_errors++; $display("FAIL unexp_final_out got=%0d exp=1", tl.outstanding_o); end
  endtask

  // Tags 2 and 4 age out together; then an asynchronous reset mid-run.
  task automatic test_dual_timeout_and_reset();
    int exp_tag;
    do_reset();
    step(1'b0, 1'b0, 0, 1'b0);
    for (int t = 0; t <= 22; t++) begin
      if (t <= 3)       step(1'b1, 1'b0, 0, 1'b0);
      else if (t == 4)  step(1'b1, 1'b1, 2, 1'b0);
      else if (t == 5)  step(1'b0, 1'b1, 0, 1'b1);
      else if (t == 6)  step(1'b0, 1'b1, 1, 1'b1);
      else if (t == 7)  step(1'b0, 1'b1, 3, 1'b1);
      else              step(1'b0, 1'b0, 0, 1'b0);
      if (t >= 5) begin
        n_checks++; if (tl.timeout_o !== (t == 21 || t == 22)) begin n_errors++; $display("FAIL dual_to t=%0d got=%0b exp=%0b", t, tl.timeout_o, t == 21 || t == 22); end
      end
      if (t == 21 || t == 22) begin
        exp_tag = (t == 21) ? 2 : 4;
        n_checks++; if (tl.timeout_tag_o !== TAG_W'(exp_tag)) begin n_errors++; $display("FAIL dual_to_tag t=%0d got=%0d exp=%0d", t, tl.timeout_tag_o, exp_tag); end
      end
    end
    n_checks++; if (tl.outstanding_o !== '0) begin n_errors++; $display("FAIL dual_out got=%0d exp=0", tl.outstanding_o); end
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (tl.tag_valid_o !== 1'b0 || tl.tag_o !== '0) begin n_errors++; $display("FAIL async_rst_offer got=%0b/%0d exp=0/0", tl.tag_valid_o, tl.tag_o); end
    n_checks++; if (tl.outstanding_o !== '0) begin n_errors++; $display("FAIL async_rst_out got=%0d exp=0", tl.outstanding_o); end
    n_checks++; if (tl.unexp_cpl_o !== 1'b0 || tl.timeout_o !== 1'b0 || tl.timeout_tag_o !== '0) begin n_errors++; $display("FAIL async_rst_evt got=%0b/%0b/%0d exp=0/0/0", tl.unexp_cpl_o, tl.timeout_o, tl.timeout_tag_o); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b1);
    n_checks++; if (tl.unexp_cpl_o !== 1'b1) begin n_errors++; $display("FAIL late_cpl_unexp got=%0b exp=1", tl.unexp_cpl_o); end
    n_checks++; if (tl.outstanding_o !== '0) begin n_errors++; $display("FAIL late_cpl_out got=%0d exp=0", tl.outstanding_o); end
  endtask

  // Random consumes and completions (hits, misses, out-of-range) against the model.
  task automatic test_random();
    bit c;
    bit cv;
    bit cl;
    int ct;
    do_reset();
    step(1'b0, 1'b0, 0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      c  = ($urandom_range(0, 99) < 55);
      cv = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 99) < 40);
      ct = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NT, 255)) : int'($urandom_range(0, NT - 1));
      step(c, cv, ct, cl);
      n_checks++; if (tl.tag_valid_o !== m_valid) begin n_errors++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, tl.tag_valid_o, m_valid); end
      if (m_valid) begin
        n_checks++; if (tl.tag_o !== TAG_W'(m_tag)) begin n_errors++; $display("FAIL rnd_tag n=%0d got=%0d exp=%0d", n, tl.tag_o, m_tag); end
      end
      n_checks++; if (tl.outstanding_o !== CNT_W'(m_out)) begin n_errors++; $display("FAIL rnd_out n=%0d got=%0d exp=%0d", n, tl.outstanding_o, m_out); end
      n_checks++; if (tl.timeout_o !== m_to) begin n_errors++; $display("FAIL rnd_to n=%0d got=%0b exp=%0b", n, tl.timeout_o, m_to); end
      if (m_to) begin
        n_checks++; if (tl.timeout_tag_o !== TAG_W'(m_to_tag)) begin n_errors++; $display("FAIL rnd_to_tag n=%0d got=%0d exp=%0d", n, tl.timeout_tag_o, m_to_tag); end
      end
      n_checks++; if (tl.unexp_cpl_o !== m_unexp) begin n_errors++; $display("FAIL rnd_unexp n=%0d got=%0b exp=%0b", n, tl.unexp_cpl_o, m_unexp); end
    end
  endtask

  initial begin
    tl.tag_consume_i = 1'b0;
    tl.cpl_valid_i   = 1'b0;
    tl.cpl_tag_i     = '0;
    tl.cpl_last_i    = 1'b0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_timeout();
    test_cpl_refresh();
    test_unexpected();
    test_dual_timeout_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
